// File: rtl/smg_pkg.sv
// ==========================================================================
// smg_pkg : segment codes and scan-state encoding for the SMG scan path
// Rev 1.0
// ==========================================================================
`default_nettype none

package smg_pkg;

  // Active-low segment codes, bit7 = DP (off)
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } smg_state_t;

endpackage

`default_nettype wire

// File: rtl/smg_digit_lut.sv
// ==========================================================================
// smg_digit_lut : combinational BCD to active-low seven-segment encoder
// Rev 1.0
// ==========================================================================
`default_nettype none

module smg_digit_lut
  import smg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/smg_scan_ctrl.sv
// ==========================================================================
// smg_scan_ctrl : multiplexed common-anode 7-seg scan controller with blank gap
// Rev 1.0
// ==========================================================================
`default_nettype none

module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load_req,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [7:0]            SMG_DATA,
  output logic [N_DIGITS-1:0]   SCAN_SIG
);

  localparam int CNT_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  smg_state_t             state, state_nx;
  logic [IDX_W-1:0]       idx, idx_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [4*N_DIGITS-1:0]  shadow_dig;
  logic [N_DIGITS-1:0]    shadow_dp;
  logic                   fs_nx, capture;
  logic [7:0]             data_nx;
  logic [N_DIGITS-1:0]    scan_nx;
  logic [7:0]             lut_seg [N_DIGITS];
  logic [7:0]             code    [N_DIGITS];
  logic [N_DIGITS-1:0]    lz_mask;
  logic                   zero_run;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lut
    smg_digit_lut u_lut (
      .bcd (shadow_dig[4*i +: 4]),
      .seg (lut_seg[i])
    );
  end

  // A digit is a leading zero when it and everything above it are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_dig[4*i +: 4] == 4'd0);
      if (i != 0) lz_mask[i] = zero_run & (LZ_BLANK != 0);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      code[i] = lz_mask[i] ? SEG_OFF : lut_seg[i];
      if (shadow_dp[i]) code[i][7] = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    fs_nx    = 1'b0;
    if (!enable) begin
      state_nx = ST_IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
          fs_nx    = 1'b1;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = ST_SHOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == SCAN_LAST) begin
            state_nx = ST_BLANK;
            cnt_nx   = '0;
            if (idx == IDX_LAST) begin
              idx_nx = '0;
              fs_nx  = 1'b1;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    // Shadow only changes between frames, so the code table is stable while lit.
    capture = load_req & ((state == ST_IDLE) | fs_nx);

    data_nx = SEG_OFF;
    scan_nx = '1;
    if (state_nx == ST_SHOW) begin
      data_nx = code[idx_nx];
      scan_nx = ~(N_DIGITS'(1) << idx_nx);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      shadow_dig  <= {N_DIGITS{4'hF}};
      shadow_dp   <= '0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      SMG_DATA    <= SEG_OFF;
      SCAN_SIG    <= '1;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      load_ack    <= capture;
      frame_start <= fs_nx;
      SMG_DATA    <= data_nx;
      SCAN_SIG    <= scan_nx;
      if (capture) begin
        shadow_dig <= digits_in;
        shadow_dp  <= dp_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_smg_scan_ctrl.sv
// ==========================================================================
// tb_smg_scan_ctrl : bench for smg_scan_ctrl (LZ on and LZ off instances)
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_smg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load_req = 1'b0;
  logic [23:0] digits_in = '0;
  logic [5:0]  dp_in = '0;
  logic        ack_a, fs_a, ack_b, fs_b;
  logic [7:0]  data_a, data_b;
  logic [5:0]  scan_a, scan_b;

  always #5 clk = ~clk;

  smg_scan_ctrl #(.N_DIGITS(6), .SCAN_CYCLES(4), .BLANK_CYCLES(2), .LZ_BLANK(1)) u_dut_lz (
    .CLK(clk), .RST(rst), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .load_req(load_req), .load_ack(ack_a), .frame_start(fs_a),
    .SMG_DATA(data_a), .SCAN_SIG(scan_a)
  );

  smg_scan_ctrl #(.N_DIGITS(6), .SCAN_CYCLES(4), .BLANK_CYCLES(2), .LZ_BLANK(0)) u_dut_nlz (
    .CLK(clk), .RST(rst), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .load_req(load_req), .load_ack(ack_b), .frame_start(fs_b),
    .SMG_DATA(data_b), .SCAN_SIG(scan_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
  } sb_t;

  typedef struct {
    logic [23:0] dig;
    logic [5:0]  dp;
    logic [47:0] ea;  // LZ on, bytes digit5..digit0
    logic [47:0] eb;  // LZ off
  } vec_t;

  sb_t  q[$];
  vec_t tbl[6];

  // Scoreboard: each newly lit digit takes the next expectation off the queue.
  logic       sb_on = 1'b0;
  logic [5:0] prev_scan = '1;
  logic [5:0] exp_scan;
  sb_t        cur;
  bit         cur_ok = 1'b0;

  always @(negedge clk) begin
    if (sb_on && scan_a != 6'h3F) begin
      if (scan_a != prev_scan) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_digit", scan_a, 6'h3F);
          cur_ok = 1'b0;
        end else begin
          cur = q.pop_front();
          cur_ok = 1'b1;
        end
      end
      if (cur_ok) begin
        exp_scan = ~(6'd1 << cur.idx);
        chk("sb_scan_lz", scan_a, exp_scan);
        chk("sb_scan_nlz", scan_b, exp_scan);
        chk("sb_data_lz", data_a, cur.a);
        chk("sb_data_nlz", data_b, cur.b);
      end
    end else if (!sb_on) begin
      cur_ok = 1'b0;
    end
    prev_scan = scan_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_scan(input logic [5:0] target, input string name);
    int c = 0;
    while (scan_a !== target && c < 100) begin
      tick();
      c++;
    end
    if (scan_a !== target) chk(name, scan_a, target);
  endtask

  task automatic push_frame(input logic [47:0] ea, input logic [47:0] eb);
    for (int i = 0; i < 6; i++) q.push_back('{idx: i, a: ea[8*i +: 8], b: eb[8*i +: 8]});
  endtask

  initial begin
    int c;
    int acks;
    tbl[0] = '{dig: 24'h000123, dp: 6'b000010, ea: 48'hFFFFFFF924B0, eb: 48'hC0C0C0F924B0};
    tbl[1] = '{dig: 24'h00A000, dp: 6'b000000, ea: 48'hFFFFFFC0C0C0, eb: 48'hC0C0FFC0C0C0};
    tbl[2] = '{dig: 24'h987654, dp: 6'b100001, ea: 48'h1080F8829219, eb: 48'h1080F8829219};
    tbl[3] = '{dig: 24'h000000, dp: 6'b000100, ea: 48'hFFFFFF7FFFC0, eb: 48'hC0C0C040C0C0};
    tbl[4] = '{dig: 24'hFEDCBA, dp: 6'b010000, ea: 48'hFF7FFFFFFFFF, eb: 48'hFF7FFFFFFFFF};
    tbl[5] = '{dig: 24'h050300, dp: 6'b000000, ea: 48'hFF92C0B0C0C0, eb: 48'hC092C0B0C0C0};

    // Reset state
    ticks(3);
    chk("rst_data", data_a, 8'hFF);
    chk("rst_scan", scan_a, 6'h3F);
    chk("rst_ack", ack_a, 1'b0);
    chk("rst_fs", fs_a, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_scan", scan_a, 6'h3F);

    // Scan timing from enable rise
    enable = 1'b1;
    tick();
    chk("en_fs", fs_a, 1'b1);
    chk("en_blank_scan", scan_a, 6'h3F);
    tick();
    chk("blank2_fs", fs_a, 1'b0);
    chk("blank2_scan", scan_a, 6'h3F);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("show0_scan", scan_a, 6'b111110);
    end
    chk("show0_data_blank_shadow", data_a, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("gap_scan", scan_a, 6'h3F);
    end
    tick();
    chk("show1_scan", scan_a, 6'b111101);
    c = 0;
    while (!fs_a && c < 60) begin tick(); c++; end
    chk("fs_seen", fs_a, 1'b1);
    c = 0;
    do begin tick(); c++; end while (!fs_a && c < 60);
    chk("frame_period", c, 36);
    enable = 1'b0;
    ticks(2);

    // Table: load in IDLE, then scoreboard one full frame on both instances
    for (int v = 0; v < 6; v++) begin
      digits_in = tbl[v].dig;
      dp_in     = tbl[v].dp;
      load_req  = 1'b1;
      tick();
      chk("idle_ack_lz", ack_a, 1'b1);
      chk("idle_ack_nlz", ack_b, 1'b1);
      chk("idle_fs", fs_a, 1'b0);
      load_req  = 1'b0;
      digits_in = 24'($urandom);
      dp_in     = 6'($urandom);
      tick();
      chk("idle_ack_drop", ack_a, 1'b0);
      push_frame(tbl[v].ea, tbl[v].eb);
      sb_on  = 1'b1;
      enable = 1'b1;
      ticks(36);
      enable = 1'b0;
      tick();
      chk("sb_drain", q.size(), 0);
      sb_on = 1'b0;
      tick();
    end

    // Enable rise together with load_req: capture and frame_start coincide
    digits_in = tbl[5].dig;
    dp_in     = tbl[5].dp;
    load_req  = 1'b1;
    enable    = 1'b1;
    tick();
    chk("simul_ack", ack_a, 1'b1);
    chk("simul_fs", fs_a, 1'b1);
    load_req = 1'b0;

    // Mid-frame request waits for the frame boundary
    wait_scan(6'b110111, "wait_digit3");
    digits_in = tbl[0].dig;
    dp_in     = tbl[0].dp;
    load_req  = 1'b1;
    tick();
    chk("midframe_old_data", data_a, 8'hC0);
    chk("midframe_no_ack", ack_a, 1'b0);
    c = 0;
    while (!fs_a && c < 60) begin
      if (ack_a) chk("early_ack", ack_a, 1'b0);
      tick();
      c++;
    end
    chk("boundary_fs", fs_a, 1'b1);
    chk("boundary_ack", ack_a, 1'b1);
    push_frame(tbl[0].ea, tbl[0].eb);
    sb_on = 1'b1;
    acks = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (ack_a) begin
        acks++;
        chk("reload_on_fs", fs_a, 1'b1);
      end
    end
    chk("reload_ack_count", acks, 1);
    sb_on    = 1'b0;
    load_req = 1'b0;
    chk("sb_drain_reload", q.size(), 0);

    // Enable dropped while digit 3 is lit
    wait_scan(6'b110111, "wait_digit3_b");
    enable = 1'b0;
    tick();
    chk("drop_data", data_a, 8'hFF);
    chk("drop_scan", scan_a, 6'h3F);
    chk("drop_fs", fs_a, 1'b0);
    tick();
    chk("drop_stay_dark", scan_a, 6'h3F);
    enable = 1'b1;
    tick();
    chk("reen_fs", fs_a, 1'b1);
    ticks(2);
    chk("reen_scan", scan_a, 6'b111110);
    chk("reen_data", data_a, 8'hB0);

    // Reset in the blank gap before digit 4, with a pending load request
    wait_scan(6'b110111, "wait_digit3_c");
    wait_scan(6'h3F, "wait_blank4");
    rst       = 1'b1;
    load_req  = 1'b1;
    digits_in = 24'h000123;
    tick();
    chk("mrst_data", data_a, 8'hFF);
    chk("mrst_scan", scan_a, 6'h3F);
    chk("mrst_ack", ack_a, 1'b0);
    chk("mrst_fs", fs_a, 1'b0);
    rst      = 1'b0;
    load_req = 1'b0;
    push_frame(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);
    sb_on = 1'b1;
    tick();
    chk("post_rst_fs", fs_a, 1'b1);
    chk("post_rst_ack", ack_a, 1'b0);
    ticks(35);
    enable = 1'b0;
    tick();
    chk("sb_drain_rst", q.size(), 0);
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
